// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: drives the select lines of a 4:1 mux through channels
// 0..3, waits SETTLE cycles per channel, samples the mux output and presents
// the assembled 4-bit frame on a valid/ready interface. Single-shot or
// continuous scanning.
module mux4_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux4_scan_ctrl: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t     state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [3:0] shd;

  // Select lines come straight from the channel register.
  assign s1 = ch[1];
  assign s0 = ch[0];

  // Scan sequencer: settle, sample, assemble frame, hold until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ch    <= '0;
      cnt   <= '0;
      shd   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ch <= '0;
          if (start) begin
            state <= ST_SETTLE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shd[ch] <= mux_out;
          cnt     <= '0;
          if (ch != 2'd3) begin
            ch    <= ch + 2'd1;
            state <= ST_SETTLE;
          end else begin
            // Channel 3 goes straight into the frame; shd[3] is not needed.
            data  <= {mux_out, shd[2:0]};
            valid <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid && ready) begin
            valid <= 1'b0;
            ch    <= '0;
            if (cont) begin
              state <= ST_SETTLE;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ch    <= '0;
          cnt   <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed testbench for mux4_scan_ctrl: one instance with SETTLE=1 and one
// with SETTLE=3, each driving a behavioural 4:1 mux model.
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       start1, cont1, ready1;
  logic [3:0] in1;
  logic       s0_1, s1_1, valid1, busy1;
  logic [3:0] data1;
  logic       mux1;

  logic       start3, cont3, ready3;
  logic [3:0] in3;
  logic       s0_3, s1_3, valid3, busy3;
  logic [3:0] data3;
  logic       mux3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux1 = in1[{s1_1, s0_1}];
  assign mux3 = in3[{s1_3, s0_3}];

  mux4_scan_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_out(mux1),
    .s0(s0_1), .s1(s1_1), .data(data1), .valid(valid1), .ready(ready1),
    .busy(busy1)
  );

  mux4_scan_ctrl #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cont(cont3), .mux_out(mux3),
    .s0(s0_3), .s1(s1_3), .data(data3), .valid(valid3), .ready(ready3),
    .busy(busy3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq [8];
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    // ---------------- reset with random inputs ----------------
    rst    = 1'b1;
    start1 = 1'($urandom); cont1 = 1'($urandom); ready1 = 1'($urandom);
    in1    = 4'($urandom);
    start3 = 1'($urandom); cont3 = 1'($urandom); ready3 = 1'($urandom);
    in3    = 4'($urandom);
    tick();
    tick();
    check_eq("rst_sel1",   {s1_1, s0_1}, 2'b00);
    check_eq("rst_data1",  data1, 4'h0);
    check_eq("rst_valid1", valid1, 1'b0);
    check_eq("rst_busy1",  busy1, 1'b0);
    check_eq("rst_sel3",   {s1_3, s0_3}, 2'b00);
    check_eq("rst_data3",  data3, 4'h0);
    check_eq("rst_valid3", valid3, 1'b0);
    check_eq("rst_busy3",  busy3, 1'b0);
    rst = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 4'h0;
    start3 = 1'b0; cont3 = 1'b0; ready3 = 1'b0; in3 = 4'h0;
    tick();

    // ---------------- single shot, SETTLE=1, ignored inputs ----------------
    in1    = 4'b1101;          // i0..i3 = 1,0,1,1
    start1 = 1'b1;
    tick();                    // E0 accepts start
    check_eq("ss_busy_rise", busy1, 1'b1);
    check_eq("ss_sel0", {s1_1, s0_1}, seq[0]);
    for (int k = 1; k < 8; k++) begin
      start1 = 1'(k % 2);      // stray start pulses during scan
      ready1 = 1'((k + 1) % 2); // ready toggling outside HOLD
      tick();
      check_eq($sformatf("ss_sel%0d", k), {s1_1, s0_1}, seq[k]);
      check_eq($sformatf("ss_novalid%0d", k), valid1, 1'b0);
      check_eq($sformatf("ss_olddata%0d", k), data1, 4'h0);
    end
    start1 = 1'b0;
    ready1 = 1'b1;
    tick();                    // E8
    check_eq("ss_valid", valid1, 1'b1);
    check_eq("ss_data",  data1, 4'b1101);
    check_eq("ss_sel_hold", {s1_1, s0_1}, 2'b11);
    tick();                    // E9 handshake, cont=0
    check_eq("ss_valid_drop", valid1, 1'b0);
    check_eq("ss_busy_fall",  busy1, 1'b0);
    check_eq("ss_data_kept",  data1, 4'b1101);
    check_eq("ss_sel_idle",   {s1_1, s0_1}, 2'b00);
    ready1 = 1'b0;
    tick();
    check_eq("ss_idle_stays", busy1, 1'b0);

    // ---------------- backpressure, SETTLE=3 ----------------
    in3    = 4'b0110;          // i0..i3 = 0,1,1,0
    start3 = 1'b1;
    tick();                    // E0
    start3 = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    check_eq("bp_valid_e15", valid3, 1'b0);
    tick();                    // E16
    check_eq("bp_valid_e16", valid3, 1'b1);
    check_eq("bp_data", data3, 4'b0110);
    in3 = 4'b1001;             // must not be sampled while holding
    for (int k = 0; k < 10; k++) begin
      start3 = 1'(k % 2);      // ignored in HOLD
      tick();
      check_eq($sformatf("bp_hold_valid%0d", k), valid3, 1'b1);
      check_eq($sformatf("bp_hold_data%0d", k), data3, 4'b0110);
      check_eq($sformatf("bp_hold_sel%0d", k), {s1_3, s0_3}, 2'b11);
    end
    start3 = 1'b0;
    ready3 = 1'b1;
    tick();
    check_eq("bp_release_valid", valid3, 1'b0);
    check_eq("bp_release_busy",  busy3, 1'b0);
    check_eq("bp_release_data",  data3, 4'b0110);
    ready3 = 1'b0;

    // ---------------- continuous mode, SETTLE=1 ----------------
    in1    = 4'b0101;          // i0..i3 = 1,0,1,0
    cont1  = 1'b1;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();                    // E0
    start1 = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    check_eq("ct_novalid_e7", valid1, 1'b0);
    tick();                    // E8
    check_eq("ct_f1_valid", valid1, 1'b1);
    check_eq("ct_f1_data",  data1, 4'b0101);
    in1 = 4'b1010;             // i0..i3 = 0,1,0,1
    tick();                    // E9 handshake with cont=1
    check_eq("ct_hs_valid", valid1, 1'b0);
    check_eq("ct_hs_busy",  busy1, 1'b1);
    check_eq("ct_hs_sel",   {s1_1, s0_1}, 2'b00);
    cont1 = 1'b0;
    for (int k = 10; k < 17; k++) tick();
    check_eq("ct_novalid_e16", valid1, 1'b0);
    check_eq("ct_data_e16",    data1, 4'b0101);
    tick();                    // E17: 9 cycles after first frame
    check_eq("ct_f2_valid", valid1, 1'b1);
    check_eq("ct_f2_data",  data1, 4'b1010);
    tick();                    // E18 handshake with cont=0
    check_eq("ct_end_valid", valid1, 1'b0);
    check_eq("ct_end_busy",  busy1, 1'b0);
    ready1 = 1'b0;
    tick();
    check_eq("ct_idle_busy", busy1, 1'b0);

    // ---------------- mid-scan reset ----------------
    in1    = 4'b0011;
    start1 = 1'b1;
    tick();                    // E0
    start1 = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check_eq("mr_sel_ch2", {s1_1, s0_1}, 2'b10);
    rst    = 1'b1;
    start1 = 1'b1;             // reset wins over start
    tick();
    check_eq("mr_sel",   {s1_1, s0_1}, 2'b00);
    check_eq("mr_data",  data1, 4'h0);
    check_eq("mr_valid", valid1, 1'b0);
    check_eq("mr_busy",  busy1, 1'b0);
    rst    = 1'b0;
    start1 = 1'b0;
    tick();
    check_eq("mr_idle_busy", busy1, 1'b0);
    in1    = 4'b1001;          // i0..i3 = 1,0,0,1
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();                    // E0
    start1 = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    check_eq("mr_novalid_e7", valid1, 1'b0);
    tick();                    // E8
    check_eq("mr_valid_new", valid1, 1'b1);
    check_eq("mr_data_new",  data1, 4'b1001);
    tick();
    check_eq("mr_done_busy", busy1, 1'b0);
    ready1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
